// File: rtl/slip_hdr_scheduler.sv
// Round-robin arbiter that latches one requester's header and serializes it onto the SLIP framer header port.
// Optional periodic null keepalive headers are enabled by defining SLIP_HDR_SCHED_KEEPALIVE_EN.
module slip_hdr_scheduler #(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int NUM_SRC          = 4,
  parameter int MAX_LEN          = 4,
  parameter int LEN_WIDTH        = 3,
  parameter int ID_WIDTH         = 2,
  parameter int KEEPALIVE_CYCLES = 1000,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC*MAX_LEN*SYMBOL_WIDTH-1:0] i_req_data,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]            i_req_len,
  input  logic [NUM_SRC-1:0]                      i_req_valid,
  output logic [NUM_SRC-1:0]                      o_req_ready,
  output logic [SYMBOL_WIDTH-1:0]                 o_hdr_data,
  output logic                                    o_hdr_null,
  output logic                                    o_hdr_last,
  output logic                                    o_hdr_valid,
  input  logic                                    i_hdr_ready,
  output logic                                    o_busy,
  output logic [ID_WIDTH-1:0]                     o_grant_id
);

  localparam int HDR_W = MAX_LEN * SYMBOL_WIDTH;
  localparam int PW    = ID_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_SRC - 1);

  if (NUM_SRC < 1 || MAX_LEN < 1 || KEEPALIVE_CYCLES < 1 || CNT_WIDTH < 1 ||
      (1 << LEN_WIDTH) <= MAX_LEN || (1 << ID_WIDTH) < NUM_SRC) begin : g_param_check
    $error("slip_hdr_scheduler: inconsistent parameters");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]    grant_q, grant_d;
  logic [LEN_WIDTH-1:0]   idx_q, idx_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [HDR_W-1:0]       hdr_q, hdr_d;
  logic [SYMBOL_WIDTH-1:0] data_q, data_d;
  logic                   null_q, null_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;

  logic                    req_any_s;
  logic [ID_WIDTH-1:0]     gnt_s;
  logic [HDR_W-1:0]        sel_hdr_s;
  logic [LEN_WIDTH-1:0]    sel_len_s;
  logic [LEN_WIDTH-1:0]    nidx_s;
  logic [SYMBOL_WIDTH-1:0] nxt_sym_s;
  logic [ID_WIDTH-1:0]     ptr_nxt_s;
  logic                    xfer_s;

`ifdef SLIP_HDR_SCHED_KEEPALIVE_EN
  localparam logic [CNT_WIDTH-1:0] KA_MAX = CNT_WIDTH'(KEEPALIVE_CYCLES - 1);
  logic [CNT_WIDTH-1:0] ka_cnt_q, ka_cnt_d;
  logic                 ka_q, ka_d;
`endif

  // Round-robin search: first requesting source at or after the pointer, with wrap
  always_comb begin
    logic [PW-1:0] cand;
    logic          hit;
    req_any_s = 1'b0;
    gnt_s     = '0;
    cand      = '0;
    hit       = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + PW'(i);
      cand = (cand >= PW'(NUM_SRC)) ? cand - PW'(NUM_SRC) : cand;
      for (int s = 0; s < NUM_SRC; s++) begin
        hit       = (cand == PW'(s)) && i_req_valid[s];
        req_any_s = req_any_s | hit;
        gnt_s     = hit ? ID_WIDTH'(s) : gnt_s;
      end
    end
  end

  // Granted slice mux, length clamp, next-symbol select and handshake outputs
  always_comb begin
    logic [LEN_WIDTH-1:0] raw_len;
    sel_hdr_s = '0;
    raw_len   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel_hdr_s = (gnt_s == ID_WIDTH'(s)) ? i_req_data[s*HDR_W +: HDR_W] : sel_hdr_s;
      raw_len   = (gnt_s == ID_WIDTH'(s)) ? i_req_len[s*LEN_WIDTH +: LEN_WIDTH] : raw_len;
    end
    sel_len_s = (raw_len > MAX_LEN_L) ? MAX_LEN_L : raw_len;
    nidx_s    = idx_q + LEN_WIDTH'(1);
    nxt_sym_s = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      nxt_sym_s = (nidx_s == LEN_WIDTH'(k)) ? hdr_q[k*SYMBOL_WIDTH +: SYMBOL_WIDTH] : nxt_sym_s;
    end
    o_req_ready = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      o_req_ready[s] = (state_q == ST_IDLE) && req_any_s && (gnt_s == ID_WIDTH'(s));
    end
    ptr_nxt_s = (grant_q == LAST_ID) ? '0 : grant_q + ID_WIDTH'(1);
    xfer_s    = valid_q & i_hdr_ready;
  end

  // Next-state logic; output symbols are prepared one cycle ahead so the o_hdr_* pins come straight from flops
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    len_d   = len_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    null_d  = null_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef SLIP_HDR_SCHED_KEEPALIVE_EN
    ka_cnt_d = ka_cnt_q;
    ka_d     = ka_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          state_d = ST_SEND;
          grant_d = gnt_s;
          idx_d   = '0;
          len_d   = sel_len_s;
          hdr_d   = sel_hdr_s;
          valid_d = 1'b1;
          null_d  = (sel_len_s == '0);
          last_d  = (sel_len_s == LEN_WIDTH'(1));
          data_d  = (sel_len_s == '0) ? '0 : sel_hdr_s[SYMBOL_WIDTH-1:0];
`ifdef SLIP_HDR_SCHED_KEEPALIVE_EN
          ka_cnt_d = '0;
          ka_d     = 1'b0;
        end else if (ka_cnt_q == KA_MAX) begin
          // Keepalive: a null header that leaves grant id and pointer untouched
          state_d = ST_SEND;
          idx_d   = '0;
          len_d   = '0;
          valid_d = 1'b1;
          null_d  = 1'b1;
          last_d  = 1'b0;
          data_d  = '0;
          ka_d    = 1'b1;
        end else begin
          ka_cnt_d = ka_cnt_q + CNT_WIDTH'(1);
        end
`else
        end else begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_SEND: begin
        if (xfer_s && (null_q || last_q)) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          null_d  = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
          idx_d   = '0;
`ifdef SLIP_HDR_SCHED_KEEPALIVE_EN
          ka_cnt_d = '0;
          ka_d     = 1'b0;
          ptr_d    = ka_q ? ptr_q : ptr_nxt_s;
`else
          ptr_d    = ptr_nxt_s;
`endif
        end else if (xfer_s) begin
          idx_d  = nidx_s;
          data_d = nxt_sym_s;
          last_d = (nidx_s == len_q - LEN_WIDTH'(1));
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        null_d  = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      null_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      null_q  <= null_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef SLIP_HDR_SCHED_KEEPALIVE_EN
  // Keepalive idle counter and in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ka_cnt_q <= '0;
      ka_q     <= 1'b0;
    end else begin
      ka_cnt_q <= ka_cnt_d;
      ka_q     <= ka_d;
    end
  end
`endif

  assign o_hdr_data  = data_q;
  assign o_hdr_null  = null_q;
  assign o_hdr_last  = last_q;
  assign o_hdr_valid = valid_q;
  assign o_busy      = (state_q == ST_SEND);
  assign o_grant_id  = grant_q;

endmodule

// File: doc/slip_hdr_scheduler.md
Name: slip_hdr_scheduler

Overview:
Round-robin scheduler that shares the SLIP framer's header input between NUM_SRC header requesters.
- Each requester presents a whole header as one packed word plus a symbol count.
- The block grants one requester, latches its header, and serializes it symbol by symbol onto the framer header stream with data/null/last/valid framing.
- It sits directly upstream of the framer's header port. Optionally it also emits periodic empty keepalive headers.

Parameters:
SYMBOL_WIDTH, 8, bits per symbol
NUM_SRC, 4, number of header requesters (>=1)
MAX_LEN, 4, maximum header length in symbols (>=1)
LEN_WIDTH, 3, width of per-source length field; must hold MAX_LEN
ID_WIDTH, 2, width of grant id; must hold NUM_SRC-1 (minimum 1)
KEEPALIVE_CYCLES, 1000, idle cycles before keepalive (used only with the optional feature)
CNT_WIDTH, 16, keepalive counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_req_data  in  NUM_SRC*MAX_LEN*SYMBOL_WIDTH  per-source header; source s occupies slice s; symbol k of a slice is at bits [k*SYMBOL_WIDTH +: SYMBOL_WIDTH]
i_req_len  in  NUM_SRC*LEN_WIDTH  per-source header length in symbols; 0 means empty header
i_req_valid  in  NUM_SRC  per-source request
o_req_ready  out  NUM_SRC  per-source accept, one-hot or zero
o_hdr_data  out  SYMBOL_WIDTH  header symbol to framer
o_hdr_null  out  1  empty header indicator
o_hdr_last  out  1  last symbol of header
o_hdr_valid  out  1  header stream valid
i_hdr_ready  in  1  framer header ready
o_busy  out  1  high while in SEND
o_grant_id  out  ID_WIDTH  source currently being serialized

Behaviour:
- Reset (async, rst high):
  - State IDLE; round-robin pointer = 0; symbol index = 0; latched length = 0; keepalive counter = 0.
  - All outputs 0.
- States: IDLE, SEND.
- IDLE:
  - Grant g = first s with i_req_valid[s]=1, scanning from pointer upward with wrap modulo NUM_SRC.
  - o_req_ready[g]=1 combinationally; all other bits 0. No valid request -> o_req_ready=0.
  - Accept (valid&&ready): latch slice g of i_req_data and i_req_len; set o_grant_id=g, index=0; go to SEND next cycle.
  - Length above MAX_LEN is clamped to MAX_LEN.
  - Requester holds valid and data stable until accepted; no retraction.
  - o_hdr_valid=0 in IDLE.
- SEND:
  - o_hdr_valid=1; o_busy=1.
  - o_hdr_data = latched symbol[index].
  - o_hdr_null = (len==0); o_hdr_data=0 when null.
  - o_hdr_last = (len!=0 && index==len-1).
  - All o_hdr_* are driven from registers only, with no combinational path from i_req_*.
- Transfer in SEND (o_hdr_valid && i_hdr_ready):
  - If null or last: go to IDLE and set pointer = (o_grant_id+1) mod NUM_SRC.
  - Otherwise index += 1.
  - Stalls (i_hdr_ready=0) hold every o_hdr_* output stable.
- Latency: request accepted in cycle N -> first header symbol valid in cycle N+1.
  - A header of L symbols occupies L cycles of SEND without backpressure (1 cycle if L=0).
  - There is 1 IDLE cycle between consecutive headers.
- Fairness: a source just served has lowest priority in the next arbitration. A continuously requesting source waits at most NUM_SRC-1 headers.
- NUM_SRC=1: pointer stays at 0; o_grant_id=0.
- Reset mid-header: the header is truncated immediately, with no last emitted. Downstream relies on the framer's own reset.
- o_req_ready is never asserted in SEND.

Optional Feature:
Macro SLIP_HDR_SCHED_KEEPALIVE_EN.
- Defined:
  - Counter increments each IDLE cycle in which no request is valid, saturating at KEEPALIVE_CYCLES-1.
  - Counter clears on any request accept and on every completed header transfer (null or last).
  - In an IDLE cycle with counter==KEEPALIVE_CYCLES-1 and no valid request, enter SEND with len=0 and an internal keepalive flag set. This produces one null header, so the framer emits a lone MARK.
  - o_grant_id holds its previous value during a keepalive.
  - The pointer is unchanged when the keepalive completes.
  - A valid request in the expiry cycle wins, and the counter clears.
- Undefined: no counter or keepalive logic; the block never emits a header without a request.

Test Plan:
1. Src1 requests len=3, data symbols 0x11,0x22,0x33, sink always ready -> o_hdr_valid for 3 cycles starting 1 cycle after accept; data 11,22,33; o_hdr_last only on 33; o_hdr_null=0 throughout.
2. Src0 requests len=0 -> single cycle with o_hdr_valid=1, o_hdr_null=1, o_hdr_data=0; back to IDLE.
3. Srcs 0,2,3 request continuously, each len=1 -> grant order 0,2,3,0,2,3; o_req_ready never has more than one bit set.
4. Len=2 header with i_hdr_ready low for 5 cycles on symbol 0 -> o_hdr_data/last/valid stable throughout; both symbols then delivered in order.
5. Src3 len=7 with MAX_LEN=4 -> exactly 4 symbols emitted, last on the 4th.
6. With SLIP_HDR_SCHED_KEEPALIVE_EN and KEEPALIVE_CYCLES=8: idle 8 cycles -> one null header; a request arriving in the expiry cycle is served instead; rst asserted mid-header -> all outputs 0 immediately.
